// File: rtl/usb_in_fifo_if.sv
// Handshake bundle between the application/usb core (master) and the IN FIFO (slave).
interface usb_in_fifo_if #(
  parameter int DEPTH   = 64,
  parameter int MAX_PKT = 8
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW = $clog2(MAX_PKT + 1);

  logic [7:0]    wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic          wr_flush;
  logic [CW-1:0] count;
  logic          pkt_avail;
  logic [LW-1:0] pkt_len;
  logic          pkt_start;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic          rd_en;
  logic          pkt_ack;
  logic          pkt_retry;

  modport master (
    output wr_data, wr_valid, wr_flush, pkt_start, rd_en, pkt_ack, pkt_retry,
    input  wr_ready, count, pkt_avail, pkt_len, rd_data, rd_valid
  );

  modport slave (
    input  wr_data, wr_valid, wr_flush, pkt_start, rd_en, pkt_ack, pkt_retry,
    output wr_ready, count, pkt_avail, pkt_len, rd_data, rd_valid
  );
endinterface

// File: rtl/usb_in_fifo.sv
// Byte FIFO + packetiser feeding the usb IN path. Packets are read speculatively
// and only committed on host ACK; a retry rewinds and replays the same packet.
module usb_in_fifo #(
  parameter int DEPTH   = 64,
  parameter int MAX_PKT = 8
) (
  input  logic         clk_48,
  input  logic         rst,
  usb_in_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW = $clog2(MAX_PKT + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] MAX_C   = CW'(MAX_PKT);
  localparam logic [LW-1:0] MAX_L   = LW'(MAX_PKT);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_HS} state_t;
  state_t state, state_nx;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, cmt_ptr, spc_ptr, sop_ptr;
  logic [LW-1:0] len_q, rem_q;
  logic          flush_pend, lock;

  logic [CW-1:0] cnt;
  logic [LW-1:0] cand_len;
  logic          wr_rdy, wr_fire;
  logic          avail, rvld, start, rd_fire, do_ack, do_retry;

  // Extra pointer bit makes full (DEPTH) and empty (0) distinguishable.
  assign cnt      = CW'(wr_ptr - cmt_ptr);
  assign wr_rdy   = cnt < DEPTH_C;
  assign wr_fire  = bus.wr_valid && wr_rdy;
  // A rewound packet keeps its original length even if more data arrived.
  assign cand_len = lock ? len_q : ((cnt >= MAX_C) ? MAX_L : LW'(cnt));

  assign bus.wr_ready  = rst || wr_rdy;
  assign bus.count     = rst ? '0 : cnt;
  assign bus.pkt_avail = !rst && avail;
  assign bus.pkt_len   = (rst || !avail) ? '0 : cand_len;
  assign bus.rd_valid  = !rst && rvld;
  assign bus.rd_data   = (rst || !rvld) ? 8'h00 : mem[spc_ptr[AW-1:0]];

  // State register.
  always_ff @(posedge clk_48) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state and handshake decode; retry beats ack and rd_en.
  always_comb begin
    state_nx = state;
    avail    = 1'b0;
    rvld     = 1'b0;
    start    = 1'b0;
    rd_fire  = 1'b0;
    do_ack   = 1'b0;
    do_retry = 1'b0;
    case (state)
      IDLE: begin
        avail = lock || (cnt >= MAX_C) || flush_pend;
        if (bus.pkt_start && avail) begin
          start    = 1'b1;
          state_nx = (cand_len == '0) ? WAIT_HS : SEND;
        end
      end
      SEND: begin
        rvld = rem_q != '0;
        if (bus.pkt_retry) begin
          do_retry = 1'b1;
          state_nx = IDLE;
        end else if (bus.rd_en && rvld) begin
          rd_fire = 1'b1;
          if (rem_q == LW'(1)) state_nx = WAIT_HS;
        end
      end
      WAIT_HS: begin
        if (bus.pkt_retry) begin
          do_retry = 1'b1;
          state_nx = IDLE;
        end else if (bus.pkt_ack) begin
          do_ack   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Byte storage; contents need no reset since pointers define validity.
  always_ff @(posedge clk_48) begin
    if (!rst && wr_fire) mem[wr_ptr[AW-1:0]] <= bus.wr_data;
  end

  // Pointers, packet length/remaining and the flush/lock flags.
  always_ff @(posedge clk_48) begin
    if (rst) begin
      wr_ptr     <= '0;
      cmt_ptr    <= '0;
      spc_ptr    <= '0;
      sop_ptr    <= '0;
      len_q      <= '0;
      rem_q      <= '0;
      flush_pend <= 1'b0;
      lock       <= 1'b0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (start) begin
        len_q   <= cand_len;
        rem_q   <= cand_len;
        sop_ptr <= cmt_ptr;
        spc_ptr <= cmt_ptr;
      end
      if (rd_fire) begin
        spc_ptr <= spc_ptr + 1'b1;
        rem_q   <= rem_q - 1'b1;
      end
      if (do_retry) begin
        spc_ptr <= sop_ptr;
        lock    <= 1'b1;
      end
      if (do_ack) begin
        cmt_ptr <= cmt_ptr + PW'(len_q);
        lock    <= 1'b0;
        // A full packet keeps a pending flush alive so a ZLP terminates the transfer.
        if (len_q < MAX_L) flush_pend <= 1'b0;
      end
      // A flush that coincides with an accepted write covers that byte too.
      if (bus.wr_flush) flush_pend <= 1'b1;
    end
  end
endmodule

// File: doc/usb_in_fifo.md
Name: usb_in_fifo

Overview:
- Byte FIFO with packetiser that sits directly upstream of the usb core's IN data path.
- Application logic pushes bytes, such as the "Tim" greeting string, with a valid/ready handshake.
- The usb core pulls whole packets of at most MAX_PKT bytes when it answers an IN token.
- A packet is committed on host ACK. On retry it is rewound and replayed identically, so bytes are never lost or duplicated.

Parameters:
- DEPTH, 64, storage in bytes; power of 2, at least MAX_PKT.
- MAX_PKT, 8, endpoint max packet size in bytes.

Ports:
- clk_48  in  1  system clock, 48 MHz.
- rst  in  1  synchronous, active-high reset.
- wr_data  in  8  byte from application.
- wr_valid  in  1  wr_data present.
- wr_ready  out  1  space available; a byte is written when wr_valid && wr_ready.
- wr_flush  in  1  one-cycle pulse: send the pending partial packet (or a ZLP).
- count  out  $clog2(DEPTH+1)  uncommitted bytes held.
- pkt_avail  out  1  a packet is ready for the core.
- pkt_len  out  $clog2(MAX_PKT+1)  length of the offered packet; valid while pkt_avail.
- pkt_start  in  1  core begins sending the offered packet; honoured only when pkt_avail.
- rd_data  out  8  current packet byte.
- rd_valid  out  1  rd_data valid.
- rd_en  in  1  core consumes rd_data; honoured only when rd_valid.
- pkt_ack  in  1  host ACKed the packet: commit it.
- pkt_retry  in  1  packet lost or aborted: rewind for retransmission.

Behaviour:
- Pointers:
  - wr_ptr, cmt_ptr (committed read), spc_ptr (speculative read), sop_ptr (packet start).
  - All are $clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
  - count = wr_ptr - cmt_ptr. wr_ready = (count < DEPTH), registered-equivalent and never combinationally dependent on wr_valid.
- Write:
  - Accepted byte goes to mem[wr_ptr]; wr_ptr increments.
  - wr_valid while !wr_ready is ignored and the byte is dropped.
  - Writes continue in every state.
- flush_pend:
  - Set by wr_flush. If wr_flush and an accepted write coincide, that byte belongs to the flushed data.
- States: IDLE, SEND, WAIT_HS.
- IDLE:
  - If lock is clear, pkt_avail = (count >= MAX_PKT) || flush_pend, and pkt_len = min(count, MAX_PKT). A flush with count==0 gives a ZLP with pkt_len=0.
  - If lock is set, pkt_avail=1 and pkt_len = locked length.
  - pkt_start && pkt_avail: latch len, set sop_ptr=spc_ptr=cmt_ptr, set remaining=len, go to SEND. If len==0, go straight to WAIT_HS.
- SEND:
  - pkt_avail=0.
  - rd_valid=1 while remaining>0, with rd_data=mem[spc_ptr].
  - rd_en: spc_ptr++, remaining--. The next byte is visible the following cycle.
  - When remaining reaches 0, go to WAIT_HS and rd_valid drops the same cycle.
- WAIT_HS:
  - rd_valid=0.
  - pkt_ack: cmt_ptr += len, clear lock; if len<MAX_PKT, clear flush_pend; go to IDLE.
  - A full MAX_PKT packet that empties the FIFO with flush_pend set leaves flush_pend set, so a ZLP follows.
- pkt_retry, in SEND or WAIT_HS: spc_ptr=sop_ptr, set lock with len unchanged, go to IDLE. The replayed packet has identical length and bytes even if more data arrived.
- Ignored inputs:
  - pkt_ack outside WAIT_HS.
  - pkt_retry in IDLE.
  - rd_en while !rd_valid.
  - pkt_start while !pkt_avail.
- pkt_ack and pkt_retry in the same cycle: retry wins; no commit.
- Data latency: first byte on rd_data the cycle after pkt_start; one byte per cycle thereafter.
- Reset: all pointers 0, flush_pend=0, lock=0, state IDLE, FIFO contents discarded. This applies mid-packet too.
- Output values in reset: wr_ready=1, count=0, pkt_avail=0, pkt_len=0, rd_valid=0, rd_data=0.
- Throughput: writes and commits in the same cycle update count correctly (count += 1 - len).

Test Plan (DEPTH=16, MAX_PKT=8):
1. Write 0x54,0x69,0x6D, no flush -> pkt_avail=0, count=3. Pulse wr_flush -> pkt_avail=1, pkt_len=3. Start, read 0x54,0x69,0x6D, ack -> count=0, pkt_avail=0.
2. Write 0x00..0x07 -> pkt_avail=1, pkt_len=8 without flush. Send, then wr_flush, ack -> ZLP offered with pkt_len=0. Start -> rd_valid stays 0. Ack -> IDLE, pkt_avail=0.
3. Write 17 bytes back-to-back -> wr_ready=0 after the 16th, 17th dropped, count=16.
4. Write 0x00..0x09, start, read 4 bytes, retry, write 2 more, start again -> pkt_len=8, rd_data restarts at 0x00. Read 8, ack -> count=4, pkt_avail=0.
5. Packet in WAIT_HS, assert pkt_ack and pkt_retry together -> count unchanged, next start replays the same bytes.
6. Assert rst mid-SEND -> next cycle count=0, pkt_avail=0, rd_valid=0, wr_ready=1.
